softusb_sof_timer: RTL

- Host-mode USB frame timer on the softusb I/O bus, alongside the free-running cycle counter peripheral.
- Divides usb_clk into 1 ms frames.
- Maintains the 11-bit USB frame number and requests a SOF token from the transmitter at each frame boundary via a req/ack handshake.
- Flags the end-of-frame guard window and raises an interrupt to the softusb CPU.

---
 rtl/softusb_sof_timer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/softusb_sof_timer.sv
// USB host frame timer: divides usb_clk into frames, tracks the 11-bit frame number,
// requests SOF tokens over a req/ack handshake and exposes CTRL/STATUS/FRAME on the I/O bus.
module softusb_sof_timer #(
    parameter logic [5:0] BASE      = 6'h24,
    parameter int         PERIOD    = 48000,
    parameter int         EOF_GUARD = 480
) (
    input  logic        usb_clk,
    input  logic        usb_rst_n,
    input  logic        io_we,
    input  logic [5:0]  io_a,
    input  logic [7:0]  io_di,
    output logic [7:0]  io_do,
    output logic        sof_req,
    input  logic        sof_ack,
    output logic [10:0] frame_nr,
    output logic        eof,
    output logic        irq
);

    localparam logic [15:0] LAST_CNT  = 16'(PERIOD - 1);
    localparam logic [15:0] EOF_START = 16'(PERIOD - EOF_GUARD);

    logic [15:0] count_q, count_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        st_sof_q, st_sof_d;
    logic        st_ovr_q, st_ovr_d;
    logic [10:0] frame_q, frame_d;
    logic [7:0]  lo_stage_q, lo_stage_d;
    logic [2:0]  hi_shadow_q, hi_shadow_d;
    logic        sof_req_q, sof_req_d;
    logic        eof_q, eof_d;
    logic [7:0]  io_do_q, io_do_d;

    // Offset relative to BASE; wraps for addresses below BASE so they fall out of range.
    logic [5:0] offset;
    logic       sel;
    logic       wr_ctrl, wr_status, wr_frame_l, wr_frame_h;
    logic       boundary;

    assign offset     = io_a - BASE;
    assign sel        = (offset[5:2] == 4'd0);
    assign wr_ctrl    = io_we & sel & (offset[1:0] == 2'd0);
    assign wr_status  = io_we & sel & (offset[1:0] == 2'd1);
    assign wr_frame_l = io_we & sel & (offset[1:0] == 2'd2);
    assign wr_frame_h = io_we & sel & (offset[1:0] == 2'd3);
    assign boundary   = en_q & (count_q == LAST_CNT);

    always_comb begin
        count_d     = 16'd0;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        st_sof_d    = st_sof_q;
        st_ovr_d    = st_ovr_q;
        frame_d     = frame_q;
        lo_stage_d  = lo_stage_q;
        hi_shadow_d = hi_shadow_q;
        sof_req_d   = sof_req_q;
        io_do_d     = 8'd0;

        if (en_q && !boundary) begin
            count_d = count_q + 16'd1;
        end
        if (sof_req_q && sof_ack) begin
            sof_req_d = 1'b0;
        end
        if (wr_status) begin
            st_sof_d = st_sof_q & ~io_di[0];
            st_ovr_d = st_ovr_q & ~io_di[1];
        end
        if (wr_frame_l) begin
            lo_stage_d = io_di;
        end
        if (wr_frame_h) begin
            frame_d = {io_di[2:0], lo_stage_q};
        end

        // Boundary events override a same-cycle clear, ack or frame commit.
        if (boundary) begin
            frame_d   = frame_q + 11'd1;
            sof_req_d = 1'b1;
            st_sof_d  = 1'b1;
            if (sof_req_q && !sof_ack) begin
                st_ovr_d = 1'b1;
            end
        end

        if (wr_ctrl) begin
            en_d     = io_di[0];
            irq_en_d = io_di[1];
            if (!io_di[0]) begin
                count_d   = 16'd0;
                sof_req_d = 1'b0;
            end
        end

        eof_d = en_d & (count_d >= EOF_START);

        if (sel) begin
            case (offset[1:0])
                2'd0: io_do_d = {6'd0, irq_en_q, en_q};
                2'd1: io_do_d = {6'd0, st_ovr_q, st_sof_q};
                2'd2: begin
                    io_do_d     = frame_q[7:0];
                    hi_shadow_d = frame_q[10:8];
                end
                default: io_do_d = {5'd0, hi_shadow_q};
            endcase
        end
    end

    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            count_q     <= 16'd0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            st_sof_q    <= 1'b0;
            st_ovr_q    <= 1'b0;
            frame_q     <= 11'd0;
            lo_stage_q  <= 8'd0;
            hi_shadow_q <= 3'd0;
            sof_req_q   <= 1'b0;
            eof_q       <= 1'b0;
            io_do_q     <= 8'd0;
        end else begin
            count_q     <= count_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            st_sof_q    <= st_sof_d;
            st_ovr_q    <= st_ovr_d;
            frame_q     <= frame_d;
            lo_stage_q  <= lo_stage_d;
            hi_shadow_q <= hi_shadow_d;
            sof_req_q   <= sof_req_d;
            eof_q       <= eof_d;
            io_do_q     <= io_do_d;
        end
    end

    assign io_do    = io_do_q;
    assign sof_req  = sof_req_q;
    assign frame_nr = frame_q;
    assign eof      = eof_q;
    assign irq      = irq_en_q & st_sof_q;

endmodule
